regfile_host_port: RTL
======================

REGFILE_HOST_PORT -- requirements
Module: regfile_host_port

Interface
REQ-001 Parameter: DATA_W, default 64, register data width.
REQ-002 Parameter: ADDR_W, default 5, register address width (32 entries).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  host request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_wr  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  ADDR_W  target register.
REQ-009 req_wdata  in  DATA_W  write data.
REQ-010 rsp_valid  out  1  response present.
REQ-011 rsp_ready  in  1  host consumes response.
REQ-012 rsp_rdata  out  DATA_W  read data, or echoed write data.
REQ-013 rsp_err  out  1  request rejected (write to register 0).
REQ-014 swaddr  out  ADDR_W  register-file side-port address.
REQ-015 swdata  out  DATA_W  register-file side-port write data.
REQ-016 swena  out  1  register-file side-port write strobe.
REQ-017 dff  in  DATA_W  register-file combinational readout of entry swaddr.
REQ-018 pipe_wena, pipe_waddr  in  1, ADDR_W  pipeline write-port snoop.
REQ-019 stall_cnt  out  16  saturating count of collision-stall cycles.

Function
REQ-020 The FSM SHALL have the states IDLE, WRITE, READ and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1, and it latches req_wr, req_addr and req_wdata.
REQ-022 An accepted request SHALL move the FSM to WRITE when req_wr=1 and to READ when req_wr=0.
REQ-023 In IDLE and RESP, swaddr, swdata and swena SHALL be 0.
REQ-024 In WRITE, swaddr and swdata SHALL carry the latched address and data.
REQ-025 A collision exists when pipe_wena=1 and pipe_waddr equals the latched address.
REQ-026 In WRITE with address 0, swena SHALL stay 0; the next state SHALL be RESP with rsp_err=1 and rsp_rdata=0.
REQ-027 In WRITE with a nonzero address and a collision, swena SHALL be 0, the FSM SHALL remain in WRITE and stall_cnt SHALL increment.
REQ-028 In WRITE with a nonzero address and no collision, swena SHALL be 1 for exactly that cycle; the next state SHALL be RESP with rsp_rdata equal to the written data and rsp_err=0.
REQ-029 In READ, swaddr SHALL carry the latched address.
REQ-030 In READ with a collision, the FSM SHALL stay in READ for that cycle and stall_cnt SHALL increment.
REQ-031 In READ without a collision, dff SHALL be captured into rsp_rdata, rsp_err SHALL be 0 and the next state SHALL be RESP.
REQ-032 A read of address 0 SHALL be legal and SHALL return the value of dff.
REQ-033 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL stay stable until rsp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-034 Minimum latency: accept at edge N, swena or swaddr valid during cycle N+1, rsp_valid from edge N+2.
REQ-035 Best-case throughput SHALL be one request every 3 cycles.
REQ-036 stall_cnt SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-037 Assertion of reset_n SHALL immediately force IDLE, and SHALL force req_ready=0 while reset_n is low, with req_ready=1 from the first edge after release.
REQ-038 Assertion of reset_n SHALL immediately force rsp_valid, rsp_err, swena, swaddr, swdata, rsp_rdata and stall_cnt to 0.
REQ-039 Reset during WRITE, READ or RESP SHALL abort the transaction with no response and no swena pulse.

Structure
REQ-040 Shared package: FSM state encoding (2-bit), DATA_W/ADDR_W defaults and the stall_cnt width.
REQ-041 One sub-module, sat_counter16 (increment enable, saturate, async active-low clear), SHALL implement stall_cnt; the rest SHALL be flat.

Verification
REQ-042 Write addr 7, data 64'hDEAD_BEEF, no pipe activity -> swena=1 for one cycle at N+1 with swaddr=7; rsp_valid at N+2 with rsp_rdata=64'hDEAD_BEEF and rsp_err=0.
REQ-043 Read addr 3 with dff=64'h3 -> rsp_rdata=64'h3 at N+2.
REQ-044 Write addr 5 with pipe_wena=1 and pipe_waddr=5 for 2 cycles -> swena delayed to N+3 and stall_cnt=2.
REQ-045 Write addr 0 -> swena never asserted, rsp_err=1 and rsp_rdata=0.
REQ-046 Hold rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0; then assert reset_n=0 while in WRITE -> all outputs 0 at once and no swena pulse.

Source files
------------

// File: rtl/regfile_host_port_pkg.sv
// Shared definitions for the register-file host port: FSM encoding and widths.
package regfile_host_port_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int STALL_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_host_port_sat_counter16.sv
// Saturating up-counter with async active-low clear; holds at all-ones.
module sat_counter16
    import regfile_host_port_pkg::*;
#(
    parameter int W = STALL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/regfile_host_port.sv
// Host request/response port onto a register-file side port, stalling on
// collisions with the pipeline write port.
module regfile_host_port
    import regfile_host_port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic [ADDR_W-1:0]  swaddr,
    output logic [DATA_W-1:0]  swdata,
    output logic               swena,
    input  logic [DATA_W-1:0]  dff,
    input  logic               pipe_wena,
    input  logic [ADDR_W-1:0]  pipe_waddr,
    output logic [STALL_W-1:0] stall_cnt
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                rdy_q;
    logic [DATA_W-1:0]   rdata_q, rdata_nxt;
    logic                err_q, err_nxt;
    logic                stall_inc;
    logic                coll, addr_zero, accept;

    assign coll      = pipe_wena && (pipe_waddr == lat_addr);
    assign addr_zero = (lat_addr == '0);
    // Ready is registered so it reads 0 throughout reset and rises on the
    // first edge after release.
    assign req_ready = rdy_q;
    assign accept    = (state == ST_IDLE) && req_valid && rdy_q;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_nxt = state;
        swaddr    = '0;
        swdata    = '0;
        swena     = 1'b0;
        stall_inc = 1'b0;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = req_wr ? ST_WRITE : ST_READ;
            end
            ST_WRITE: begin
                swaddr = lat_addr;
                swdata = lat_wdata;
                // Register 0 is read-only: reject before looking at collisions.
                if (addr_zero) begin
                    state_nxt = ST_RESP;
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                end else if (coll) begin
                    stall_inc = 1'b1;
                end else begin
                    swena     = 1'b1;
                    state_nxt = ST_RESP;
                    rdata_nxt = lat_wdata;
                    err_nxt   = 1'b0;
                end
            end
            ST_READ: begin
                swaddr = lat_addr;
                if (coll) begin
                    stall_inc = 1'b1;
                end else begin
                    state_nxt = ST_RESP;
                    rdata_nxt = dff;
                    err_nxt   = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rdy_q     <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            rdy_q   <= (state_nxt == ST_IDLE);
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            if (accept) begin
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
        end
    end

    sat_counter16 #(.W(STALL_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

endmodule
